// File: rtl/mod_n_down_counter.sv
// mod_n_down_counter: programmable mod-N down-counter / timer.
//
// Counts N-1 down to 0 under an IDLE/RUN/DONE control FSM and emits a
// one-cycle registered terminal-count pulse (tc) on every expiry. In
// continuous mode the counter reloads to N-1 on expiry and keeps running;
// in one-shot mode it parks at 0 in DONE. A synchronous preload (load)
// overrides the count path in any state.
//
// Optional feature macro: MOD_N_DOWN_WRAPCNT_EN
//   When defined, adds output wraps[7:0], a saturating count of expiries
//   that is cleared whenever a start is accepted from IDLE or DONE.

module mod_n_down_counter #(
  parameter int N      = 6,
  parameter int LENGTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic              continuous,
  input  logic              load,
  input  logic [LENGTH-1:0] load_val,
  output logic [LENGTH-1:0] counter,
  output logic              tc,
  output logic              busy,
`ifdef MOD_N_DOWN_WRAPCNT_EN
  output logic              done,
  output logic [7:0]        wraps
`else
  output logic              done
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LENGTH-1:0] TOP  = LENGTH'(N - 1);
  localparam logic [LENGTH-1:0] ZERO = '0;
  localparam logic [LENGTH-1:0] ONE  = LENGTH'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [LENGTH-1:0] counter_nxt;
  logic              tc_nxt;
  logic              start_ok;
  logic              run_count;
  logic              expire;

  // Preload values beyond the modulus are pulled back to the top count.
  function automatic logic [LENGTH-1:0] clamp_load(input logic [LENGTH-1:0] v);
    return (v > TOP) ? TOP : v;
  endfunction

  // A counting cycle needs RUN, no stop, enable high and no preload competing.
  always_comb begin
    run_count = (state == RUN) && !stop && en && !load;
    expire    = run_count && (counter == ZERO);
    start_ok  = start && ((state == IDLE) || (state == DONE));
  end

  // Next-state and next-count decode; load overrides only the counter path.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    tc_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          counter_nxt = TOP;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (run_count) begin
          if (counter != ZERO) begin
            counter_nxt = counter - ONE;
          end else begin
            tc_nxt = 1'b1;
            if (continuous) counter_nxt = TOP;
            else            state_nxt   = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_nxt   = RUN;
          counter_nxt = TOP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (load) begin
      counter_nxt = clamp_load(load_val);
      tc_nxt      = 1'b0;
    end
  end

  // Control and count registers; async active-low reset cancels any pending tc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= TOP;
      tc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      tc      <= tc_nxt;
    end
  end

  // Status flags come straight from the state register, so they never glitch.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

`ifdef MOD_N_DOWN_WRAPCNT_EN
  // Expiry counter: updates on the same edge that raises tc, saturates at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wraps <= 8'd0;
    end else if (start_ok) begin
      wraps <= 8'd0;
    end else if (expire && (wraps != 8'hFF)) begin
      wraps <= wraps + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_n_down_counter.sv
// tb_mod_n_down_counter: directed, table-driven bench for mod_n_down_counter
// with N=6, LENGTH=3. Define MOD_N_DOWN_WRAPCNT_EN to also exercise wraps.

module tb_mod_n_down_counter;

  localparam int N      = 6;
  localparam int LENGTH = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              en = 1'b0;
  logic              continuous = 1'b0;
  logic              load = 1'b0;
  logic [LENGTH-1:0] load_val = '0;
  logic [LENGTH-1:0] counter;
  logic              tc;
  logic              busy;
  logic              done;
`ifdef MOD_N_DOWN_WRAPCNT_EN
  logic [7:0]        wraps;
`endif

  int checks = 0;
  int errors = 0;

  mod_n_down_counter #(.N(N), .LENGTH(LENGTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .continuous (continuous),
    .load       (load),
    .load_val   (load_val),
    .counter    (counter),
    .tc         (tc),
    .busy       (busy),
`ifdef MOD_N_DOWN_WRAPCNT_EN
    .done       (done),
    .wraps      (wraps)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sp;
    logic       e;
    logic       ct;
    logic       ld;
    logic [2:0] lv;
    logic [2:0] ecnt;
    logic       etc;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sp, input logic e, input logic ct,
                     input logic ld, input logic [2:0] lv, input logic [2:0] ecnt,
                     input logic etc, input logic ebusy, input logic edone);
    vec_t v;
    v.st = st; v.sp = sp; v.e = e; v.ct = ct; v.ld = ld; v.lv = lv;
    v.ecnt = ecnt; v.etc = etc; v.ebusy = ebusy; v.edone = edone;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ecnt, input int etc,
                         input int ebusy, input int edone);
    chk({tag, " counter"}, 32'(counter), 32'(ecnt));
    chk({tag, " tc"},      32'(tc),      32'(etc));
    chk({tag, " busy"},    32'(busy),    32'(ebusy));
    chk({tag, " done"},    32'(done),    32'(edone));
  endtask

  task automatic drive(input logic st, input logic sp, input logic e, input logic ct,
                       input logic ld, input logic [2:0] lv);
    start = st; stop = sp; en = e; continuous = ct; load = ld; load_val = lv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    // start sp  en  ct  ld  lv   | cnt tc busy done
    // one-shot run from IDLE
    add(1, 0, 1, 0, 0, 3'd0,  3'd5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 3'd0,  3'd0, 0, 0, 1);
    // enable gating, stop, restart
    add(1, 0, 0, 0, 0, 3'd0,  3'd5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3'd0,  3'd4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3'd0,  3'd3, 0, 1, 0);
    add(0, 1, 1, 0, 0, 3'd0,  3'd3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd3, 0, 0, 0);
    add(1, 0, 1, 0, 0, 3'd0,  3'd5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd4, 0, 1, 0);
    // load in RUN, then run out
    add(0, 0, 1, 0, 1, 3'd2,  3'd2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 1, 0, 1);
    // clamped load in DONE and in RUN
    add(0, 0, 0, 0, 1, 3'd7,  3'd5, 0, 0, 1);
    add(1, 0, 1, 0, 0, 3'd0,  3'd5, 0, 1, 0);
    add(0, 0, 1, 0, 1, 3'd7,  3'd5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd4, 0, 1, 0);
    // stop beats count; start+load from IDLE takes the load value
    add(0, 1, 1, 0, 0, 3'd0,  3'd4, 0, 0, 0);
    add(1, 0, 0, 0, 1, 3'd1,  3'd1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 0, 1, 0);
    // stop on the expiry cycle: no tc, counter stays 0, back to IDLE
    add(0, 1, 1, 0, 0, 3'd0,  3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd0,  3'd0, 0, 0, 0);

    // reset state, sampled while reset is held low across clock edges
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 5, 0, 0, 0);
`ifdef MOD_N_DOWN_WRAPCNT_EN
    chk("reset wraps", 32'(wraps), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_out("idle hold", 5, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].e, vecs[i].ct, vecs[i].ld, vecs[i].lv);
      step();
      chk_out($sformatf("vec%0d", i), int'(vecs[i].ecnt), int'(vecs[i].etc),
              int'(vecs[i].ebusy), int'(vecs[i].edone));
    end

    // continuous: tc every N cycles, busy never drops
    drive(1, 0, 1, 1, 0, 3'd0);
    step();
    chk_out("cont k0", 5, 0, 1, 0);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 1, 1, 0, 3'd0);
      step();
      if (tc === 1'b1) pulses++;
      chk_out($sformatf("cont k%0d", k), 5 - (k % 6), (k % 6 == 0) ? 1 : 0, 1, 0);
    end
    chk("cont pulses", 32'(pulses), 32'd3);
    drive(0, 1, 1, 1, 0, 3'd0);
    step();
    chk_out("cont stop", 3, 0, 0, 0);

    // asynchronous reset mid-count, observed between clock edges
    drive(1, 0, 1, 0, 0, 3'd0);
    step();
    drive(0, 0, 1, 0, 0, 3'd0);
    step();
    step();
    step();
    chk_out("pre async", 2, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async reset", 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_out("post reset idle", 5, 0, 0, 0);

`ifdef MOD_N_DOWN_WRAPCNT_EN
    // wraps: 60 cycles of continuous counting give 10 expiries
    drive(1, 0, 1, 1, 0, 3'd0);
    step();
    for (int k = 1; k <= 60; k++) begin
      drive(0, 0, 1, 1, 0, 3'd0);
      step();
    end
    chk("wraps after 60", 32'(wraps), 32'd10);
    drive(0, 1, 0, 1, 0, 3'd0);
    step();
    chk("wraps held idle", 32'(wraps), 32'd10);
    drive(1, 0, 0, 1, 0, 3'd0);
    step();
    chk("wraps cleared", 32'(wraps), 32'd0);
    chk_out("wraps restart", 5, 0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
